// File: rtl/cp0_timer_irq_if.sv
// CP0 side-band bus: mfc0/mtc0 access, commit-stage exception info and interrupt outputs.
interface cp0_timer_irq_if #(
    parameter int unsigned NUM_HWINT = 5
);
    logic [4:0]           A1;
    logic [4:0]           A2;
    logic [31:0]          DIn;
    logic                 CPWr;
    logic [31:0]          DOut;
    logic [31:0]          PC;
    logic                 BD;
    logic [4:0]           ExcCode;
    logic [31:0]          BadVA;
    logic [NUM_HWINT-1:0] HWInt;
    logic                 EXLClr;
    logic                 IntReq;
    logic [31:0]          EPC;
    logic                 TimerIrq;

    modport slave (
        input  A1, A2, DIn, CPWr, PC, BD, ExcCode, BadVA, HWInt, EXLClr,
        output DOut, IntReq, EPC, TimerIrq
    );

    modport master (
        output A1, A2, DIn, CPWr, PC, BD, ExcCode, BadVA, HWInt, EXLClr,
        input  DOut, IntReq, EPC, TimerIrq
    );
endinterface

// File: rtl/cp0_timer_irq.sv
// Coprocessor-0: SR/Cause/EPC/PRId/BadVAddr plus a Count/Compare timer feeding
// the top interrupt line; decides handler entry for the committing instruction.
module cp0_timer_irq #(
    parameter int unsigned NUM_HWINT = 5,
    parameter bit          HAS_TIMER = 1'b1,
    parameter logic [31:0] PRID_VAL  = 32'h2437_1277
) (
    input logic           clk,
    input logic           reset,
    cp0_timer_irq_if.slave bus
);
    localparam int unsigned N      = NUM_HWINT + 1;
    localparam int unsigned IP_LSB = 10;

    logic [N-1:0] im;
    logic         exl;
    logic         ie;
    logic         cause_bd;
    logic [N-1:0] ip;
    logic [4:0]   exc_code;
    logic [31:0]  epc;
    logic [31:0]  bad_vaddr;
    logic [31:0]  count;
    logic [31:0]  compare;
    logic         ti;

    logic [N-1:0] lines;
    logic         irq;
    logic         int_req;
    logic         wr;
    logic         wr_count;
    logic         wr_compare;
    logic [31:0]  sr_rd;
    logic [31:0]  cause_rd;

    assign lines   = {ti, bus.HWInt};
    assign irq     = ie & (|(lines & im));
    assign int_req = ~exl & (irq | (bus.ExcCode != 5'd0));

    // An mtc0 is dropped whenever the same cycle enters the handler.
    assign wr         = bus.CPWr & ~int_req;
    assign wr_count   = wr & (bus.A2 == 5'd9);
    assign wr_compare = wr & (bus.A2 == 5'd11);

    assign sr_rd    = (32'(im) << IP_LSB) | {30'd0, exl, ie};
    assign cause_rd = {cause_bd, 31'd0} | (32'(ip) << IP_LSB) | (32'(exc_code) << 2);

    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            5'd8:    bus.DOut = bad_vaddr;
            5'd9:    bus.DOut = count;
            5'd11:   bus.DOut = compare;
            5'd12:   bus.DOut = sr_rd;
            5'd13:   bus.DOut = cause_rd;
            5'd14:   bus.DOut = epc;
            5'd15:   bus.DOut = PRID_VAL;
            default: bus.DOut = 32'd0;
        endcase
    end

    assign bus.IntReq   = int_req;
    assign bus.EPC      = epc;
    assign bus.TimerIrq = ti;

    // Exception/interrupt state; handler entry takes precedence over eret and mtc0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im        <= '0;
            exl       <= 1'b0;
            ie        <= 1'b0;
            cause_bd  <= 1'b0;
            ip        <= '0;
            exc_code  <= 5'd0;
            epc       <= 32'd0;
            bad_vaddr <= 32'd0;
        end else begin
            ip <= lines;
            if (int_req) begin
                exl      <= 1'b1;
                cause_bd <= bus.BD;
                epc      <= bus.BD ? (bus.PC - 32'd4) : bus.PC;
                exc_code <= irq ? 5'd0 : bus.ExcCode;
                if (!irq && (bus.ExcCode == 5'd4 || bus.ExcCode == 5'd5)) begin
                    bad_vaddr <= bus.BadVA;
                end
            end else begin
                if (bus.EXLClr) begin
                    exl <= 1'b0;
                end
                if (wr && bus.A2 == 5'd12) begin
                    im  <= bus.DIn[IP_LSB +: N];
                    exl <= bus.DIn[1];
                    ie  <= bus.DIn[0];
                end
                if (wr && bus.A2 == 5'd14) begin
                    epc <= {bus.DIn[31:2], 2'b00};
                end
            end
        end
    end

    if (HAS_TIMER) begin : g_timer
        // Free-running counter; a Compare write clears TI and beats a same-edge match.
        always_ff @(posedge clk) begin
            if (!reset) begin
                count   <= 32'd0;
                compare <= 32'd0;
                ti      <= 1'b0;
            end else begin
                count <= wr_count ? bus.DIn : (count + 32'd1);
                if (wr_compare) begin
                    compare <= bus.DIn;
                    ti      <= 1'b0;
                end else if (count == compare) begin
                    ti <= 1'b1;
                end
            end
        end
    end else begin : g_no_timer
        assign count   = 32'd0;
        assign compare = 32'd0;
        assign ti      = 1'b0;
    end
endmodule

// File: tb/tb_cp0_timer_irq.sv
// Scoreboard bench for cp0_timer_irq: directed stimulus queues expectations, a monitor checks them.
module tb_cp0_timer_irq;
    localparam logic [31:0] PRID = 32'h2437_1277;
    localparam int SEL_DOUT  = 0;
    localparam int SEL_IRQ   = 1;
    localparam int SEL_EPC   = 2;
    localparam int SEL_TI    = 3;
    localparam int SEL_DOUT2 = 4;
    localparam int SEL_TI2   = 5;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic reset;

    cp0_timer_irq_if #(.NUM_HWINT(5)) bus  ();
    cp0_timer_irq_if #(.NUM_HWINT(2)) bus2 ();

    cp0_timer_irq #(.NUM_HWINT(5), .HAS_TIMER(1'b1), .PRID_VAL(PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    cp0_timer_irq #(.NUM_HWINT(2), .HAS_TIMER(1'b0), .PRID_VAL(PRID)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    exp_t q[$];
    event smp;
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Monitor: drains every queued expectation against the live DUT outputs.
    always @(smp) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                SEL_DOUT:  act = bus.DOut;
                SEL_IRQ:   act = 32'(bus.IntReq);
                SEL_EPC:   act = bus.EPC;
                SEL_TI:    act = 32'(bus.TimerIrq);
                SEL_DOUT2: act = bus2.DOut;
                default:   act = 32'(bus2.TimerIrq);
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.val);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int sel, input logic [4:0] a, input logic [31:0] val,
                            input string name);
        exp_t e;
        if (sel == SEL_DOUT)  bus.A1  = a;
        if (sel == SEL_DOUT2) bus2.A1 = a;
        #1;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        q.push_back(e);
        ->smp;
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] val, input string name);
        expect_v(SEL_DOUT, a, val, name);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.CPWr = 1'b1;
        bus.A2   = a;
        bus.DIn  = d;
        step();
        bus.CPWr = 1'b0;
    endtask

    task automatic mtc0_2(input logic [4:0] a, input logic [31:0] d);
        bus2.CPWr = 1'b1;
        bus2.A2   = a;
        bus2.DIn  = d;
        step();
        bus2.CPWr = 1'b0;
    endtask

    task automatic exl_clr();
        bus.EXLClr = 1'b1;
        step();
        bus.EXLClr = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {bus.A1, bus.A2, bus.DIn, bus.CPWr, bus.PC, bus.BD} = '0;
        {bus.ExcCode, bus.BadVA, bus.HWInt, bus.EXLClr}     = '0;
        {bus2.A1, bus2.A2, bus2.DIn, bus2.CPWr, bus2.PC, bus2.BD} = '0;
        {bus2.ExcCode, bus2.BadVA, bus2.HWInt, bus2.EXLClr}      = '0;

        // Reset state
        step();
        step();
        expect_v(SEL_IRQ, 5'd0, 32'd0, "rst_intreq");
        expect_v(SEL_EPC, 5'd0, 32'd0, "rst_epc");
        expect_v(SEL_TI, 5'd0, 32'd0, "rst_ti");
        rd(5'd12, 32'd0, "rst_sr");
        rd(5'd13, 32'd0, "rst_cause");
        rd(5'd9, 32'd0, "rst_count");
        rd(5'd15, PRID, "prid");
        rd(5'd3, 32'd0, "unmapped_reg");
        reset = 1'b1;

        // SR writable mask; first edge out of reset also raises TI
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, 32'h0000_FC03, "sr_mask");
        expect_v(SEL_TI, 5'd0, 32'd1, "ti_after_reset");
        expect_v(SEL_IRQ, 5'd0, 32'd0, "irq_blocked_exl");
        rd(5'd9, 32'd1, "count_first");
        rd(5'd11, 32'd0, "compare_rst");
        mtc0(5'd12, 32'd0);
        rd(5'd12, 32'd0, "sr_zero");

        // Address-error exception in a delay slot
        bus.ExcCode = 5'd4;
        bus.BadVA   = 32'h0000_3001;
        bus.PC      = 32'h0000_3010;
        bus.BD      = 1'b1;
        expect_v(SEL_IRQ, 5'd0, 32'd1, "exc_intreq");
        step();
        bus.ExcCode = 5'd0;
        bus.BD      = 1'b0;
        expect_v(SEL_EPC, 5'd0, 32'h0000_300C, "exc_epc_bd");
        rd(5'd13, 32'h8000_8010, "exc_cause");
        rd(5'd8, 32'h0000_3001, "exc_badva");
        rd(5'd12, 32'h0000_0002, "exc_exl");
        bus.ExcCode = 5'd10;
        expect_v(SEL_IRQ, 5'd0, 32'd0, "exl_blocks_exc");
        bus.ExcCode = 5'd0;
        exl_clr();
        rd(5'd12, 32'd0, "eret_sr");

        // Interrupt beats simultaneous exception; BadVAddr kept
        mtc0(5'd12, 32'h0000_0401);
        bus.HWInt   = 5'b00001;
        bus.ExcCode = 5'd10;
        bus.PC      = 32'h0000_4000;
        expect_v(SEL_IRQ, 5'd0, 32'd1, "int_intreq");
        step();
        bus.HWInt   = '0;
        bus.ExcCode = 5'd0;
        rd(5'd13, 32'h0000_8400, "int_cause");
        rd(5'd8, 32'h0000_3001, "int_badva_kept");
        expect_v(SEL_EPC, 5'd0, 32'h0000_4000, "int_epc");
        rd(5'd12, 32'h0000_0403, "int_sr");
        exl_clr();

        // Masked interrupt: IntReq follows ExcCode only
        mtc0(5'd12, 32'h0000_0001);
        bus.HWInt = 5'b00001;
        expect_v(SEL_IRQ, 5'd0, 32'd0, "masked_no_irq");
        bus.ExcCode = 5'd10;
        bus.PC      = 32'h0000_5000;
        expect_v(SEL_IRQ, 5'd0, 32'd1, "masked_exc_irq");
        step();
        bus.HWInt   = '0;
        bus.ExcCode = 5'd0;
        rd(5'd13, 32'h0000_8428, "masked_cause");
        expect_v(SEL_EPC, 5'd0, 32'h0000_5000, "masked_epc");
        rd(5'd8, 32'h0000_3001, "ri_badva_kept");
        exl_clr();

        // mtc0 EPC colliding with entry is discarded
        bus.ExcCode = 5'd5;
        bus.BadVA   = 32'hDEAD_BEEF;
        bus.PC      = 32'h0000_6000;
        mtc0(5'd14, 32'h0000_1234);
        bus.ExcCode = 5'd0;
        expect_v(SEL_EPC, 5'd0, 32'h0000_6000, "collide_epc");
        rd(5'd8, 32'hDEAD_BEEF, "collide_badva");
        rd(5'd13, 32'h0000_8014, "collide_cause");

        // eret with a pending unmasked interrupt
        mtc0(5'd12, 32'h0000_0403);
        bus.HWInt = 5'b00001;
        expect_v(SEL_IRQ, 5'd0, 32'd0, "pend_exl_irq");
        exl_clr();
        rd(5'd12, 32'h0000_0401, "eret_pend_sr");
        expect_v(SEL_IRQ, 5'd0, 32'd1, "eret_pend_irq");
        bus.PC = 32'h0000_7000;
        exl_clr();
        bus.HWInt = '0;
        rd(5'd12, 32'h0000_0403, "entry_beats_eret");
        expect_v(SEL_EPC, 5'd0, 32'h0000_7000, "entry_eret_epc");
        exl_clr();

        // Timer match raises TI, then a timer interrupt
        mtc0(5'd11, 32'd20);
        expect_v(SEL_TI, 5'd0, 32'd0, "cmp_clears_ti");
        mtc0(5'd9, 32'd10);
        rd(5'd9, 32'd10, "count_write");
        mtc0(5'd12, 32'h0000_8001);
        repeat (9) step();
        expect_v(SEL_TI, 5'd0, 32'd0, "ti_before_match");
        expect_v(SEL_IRQ, 5'd0, 32'd0, "irq_before_match");
        rd(5'd9, 32'd20, "count_at_match");
        bus.PC = 32'h0000_8000;
        step();
        expect_v(SEL_TI, 5'd0, 32'd1, "ti_match");
        expect_v(SEL_IRQ, 5'd0, 32'd1, "timer_intreq");
        step();
        rd(5'd13, 32'h0000_8000, "timer_cause");
        expect_v(SEL_EPC, 5'd0, 32'h0000_8000, "timer_epc");
        expect_v(SEL_IRQ, 5'd0, 32'd0, "timer_exl");
        mtc0(5'd11, 32'h0000_0100);
        expect_v(SEL_TI, 5'd0, 32'd0, "cmp_write_clears");
        exl_clr();
        rd(5'd12, 32'h0000_8001, "timer_eret_sr");

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFE);
        rd(5'd9, 32'hFFFF_FFFE, "wrap_load");
        step();
        rd(5'd9, 32'hFFFF_FFFF, "wrap_max");
        step();
        rd(5'd9, 32'h0000_0000, "wrap_zero");

        // Reset mid-operation aborts entry and mtc0
        reset       = 1'b0;
        bus.ExcCode = 5'd4;
        bus.BadVA   = 32'h0000_0ABC;
        mtc0(5'd14, 32'h0000_0ABC);
        bus.ExcCode = 5'd0;
        expect_v(SEL_EPC, 5'd0, 32'd0, "midrst_epc");
        rd(5'd12, 32'd0, "midrst_sr");
        rd(5'd8, 32'd0, "midrst_badva");
        rd(5'd11, 32'd0, "midrst_compare");
        expect_v(SEL_TI, 5'd0, 32'd0, "midrst_ti");
        reset = 1'b1;

        // No-timer variant with two hardware lines
        mtc0_2(5'd9, 32'd55);
        mtc0_2(5'd11, 32'd77);
        expect_v(SEL_DOUT2, 5'd9, 32'd0, "nt_count");
        expect_v(SEL_DOUT2, 5'd11, 32'd0, "nt_compare");
        mtc0_2(5'd12, 32'hFFFF_FFFF);
        expect_v(SEL_DOUT2, 5'd12, 32'h0000_1C03, "nt_sr_mask");
        expect_v(SEL_DOUT2, 5'd15, PRID, "nt_prid");
        for (int i = 0; i < 10; i++) begin
            repeat (100) step();
            expect_v(SEL_TI2, 5'd0, 32'd0, "nt_ti_low");
        end

        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
